// File: rtl/alu_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_add_sequencer
// Brief    : Multi-precision add/subtract sequencer driving an external 6-bit
//            ripple adder, one chunk per clock, LSB chunk first.
//            Optional signed-overflow output: ALU_ADD_SEQ_OVERFLOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_add_sequencer #(
    parameter int CHUNKS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [6*CHUNKS-1:0]   op_a,
    input  logic [6*CHUNKS-1:0]   op_b,
    input  logic                  op_sub,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [6*CHUNKS-1:0]   result,
    output logic                  carry_out,
    output logic                  overflow,
    output logic [5:0]            add_a,
    output logic [5:0]            add_b,
    output logic                  add_cin,
    input  logic [5:0]            add_sum,
    input  logic                  add_cout
);

    localparam int c_width = 6 * CHUNKS;
    localparam int c_idx_w = $clog2(CHUNKS);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(CHUNKS - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]          r_state;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_width-1:0]  r_a;
    logic [c_width-1:0]  r_b;
    logic                r_carry;
    logic [c_width-1:0]  r_result;
    logic                r_carry_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        // Subtract is A + ~B + 1: invert B here, inject the 1 as first carry-in
                        r_a         <= op_a;
                        r_b         <= op_b ^ {c_width{op_sub}};
                        r_carry     <= op_sub;
                        r_idx       <= '0;
                        r_result    <= '0;
                        r_carry_out <= 1'b0;
                        r_state     <= c_st_run;
                    end
                end
                c_st_run: begin
                    r_result[6*r_idx +: 6] <= add_sum;
                    r_carry                <= add_cout;
                    if (r_idx == c_last_idx) begin
                        r_carry_out <= add_cout;
                        r_state     <= c_st_done;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_st_done: begin
                    if (resp_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

`ifdef ALU_ADD_SEQ_OVERFLOW_EN
    logic r_overflow;

    // Registered on the last chunk so the flag never shows partial-result glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (r_state == c_st_idle && req_valid) begin
            r_overflow <= 1'b0;
        end else if (r_state == c_st_run && r_idx == c_last_idx) begin
            r_overflow <= (r_a[c_width-1] == r_b[c_width-1]) &&
                          (add_sum[5] != r_a[c_width-1]);
        end
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

    assign req_ready  = (r_state == c_st_idle);
    assign resp_valid = (r_state == c_st_done);
    assign result     = r_result;
    assign carry_out  = r_carry_out;
    assign add_a      = (r_state == c_st_run) ? r_a[6*r_idx +: 6] : 6'd0;
    assign add_b      = (r_state == c_st_run) ? r_b[6*r_idx +: 6] : 6'd0;
    assign add_cin    = (r_state == c_st_run) ? r_carry : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_alu_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_add_sequencer
// Brief    : Self-checking bench with an arithmetic reference model and a
//            behavioural six_bit_adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_add_sequencer;

    localparam int CHUNKS = 4;
    localparam int W      = 6 * CHUNKS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          op_sub = 1'b0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [W-1:0]  result;
    logic          carry_out;
    logic          overflow;
    logic [5:0]    add_a;
    logic [5:0]    add_b;
    logic          add_cin;
    logic [5:0]    add_sum;
    logic          add_cout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] e_a, e_bb, e_res;
    logic         e_sub, e_c, e_v;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = add_a + add_b + {5'd0, add_cin};

    alu_add_sequencer #(.CHUNKS(CHUNKS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_sub     (op_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .carry_out  (carry_out),
        .overflow   (overflow),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_sum    (add_sum),
        .add_cout   (add_cout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain W-bit arithmetic and exact signed range test
    task automatic set_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W:0] t;
        longint sa, sb, exact;
        e_a   = a;
        e_bb  = sub ? ~b : b;
        e_sub = sub;
        if (sub) begin
            t   = {1'b0, a} - {1'b0, b};
            e_c = ~t[W];
        end else begin
            t   = {1'b0, a} + {1'b0, b};
            e_c = t[W];
        end
        e_res = t[W-1:0];
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        exact = sub ? sa - sb : sa + sb;
`ifdef ALU_ADD_SEQ_OVERFLOW_EN
        e_v = (exact > (64'sd1 <<< (W-1)) - 1) || (exact < -(64'sd1 <<< (W-1)));
`else
        e_v = 1'b0;
`endif
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        op_a      = a;
        op_b      = b;
        op_sub    = sub;
        set_model(a, b, sub);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic track();
        logic [63:0] m;
        logic [63:0] cin_exp;
        for (int k = 0; k < CHUNKS; k++) begin
            @(negedge clk);
            m       = (64'd1 << (6 * k)) - 64'd1;
            cin_exp = ((64'(e_a) & m) + (64'(e_bb) & m) + 64'(e_sub)) >> (6 * k);
            chk("add_a", add_a, (64'(e_a) >> (6 * k)) & 64'h3f);
            chk("add_b", add_b, (64'(e_bb) >> (6 * k)) & 64'h3f);
            chk("add_cin", add_cin, cin_exp);
            chk("run_req_ready", req_ready, 0);
            chk("run_resp_valid", resp_valid, 0);
        end
        @(negedge clk);
        chk("resp_valid", resp_valid, 1);
        chk("result", result, e_res);
        chk("carry_out", carry_out, e_c);
        chk("overflow", overflow, e_v);
        chk("done_add_a", add_a, 0);
        chk("done_add_cin", add_cin, 0);
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("post_req_ready", req_ready, 1);
        chk("post_resp_valid", resp_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_carry_out"}, carry_out, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_add_abcin"}, {add_a, add_b, add_cin}, 0);
    endtask

    initial begin
        // Reset state
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        issue(24'h00003F, 24'h000001, 1'b0); track(); release_resp();
        issue(24'hFFFFFF, 24'h000001, 1'b0); track(); release_resp();
        issue(24'h7FFFFF, 24'h000001, 1'b0); track();
        chk("ovf_pos_add_result", result, 24'h800000);
        release_resp();
        issue(24'h000000, 24'h000001, 1'b1); track();
        chk("sub_borrow_result", {carry_out, result}, {1'b0, 24'hFFFFFF});
        release_resp();
        issue(24'h800000, 24'h000001, 1'b1); track(); release_resp();

        // Held response with a competing request
        issue(24'h123456, 24'h0FEDCB, 1'b0); track();
        req_valid = 1'b1;
        op_a      = 24'h00ABCD;
        op_b      = 24'h001111;
        op_sub    = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_resp_valid", resp_valid, 1);
            chk("hold_result", result, e_res);
            chk("hold_carry_out", carry_out, e_c);
            chk("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("hold_release_req_ready", req_ready, 1);
        set_model(24'h00ABCD, 24'h001111, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        track();
        release_resp();

        // Asynchronous reset during the third RUN cycle
        issue(24'h0F0F0F, 24'h010101, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        issue(24'h000010, 24'h000020, 1'b0); track();
        chk("after_reset_result", result, 24'h000030);
        release_resp();

        // Random operations; early resp_ready on odd iterations must not cut RUN short
        for (int i = 0; i < 24; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            if (i % 2 == 1) resp_ready = 1'b1;
            track();
            release_resp();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
